// File: rtl/mult_share_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
//   OP_W / PROD_W  : operand and product widths
//   arb_state_t    : arbiter controller states
//   mult_state_t   : state encoding of multiplicador_4bits (fsm_state_o),
//                    defined once here and used by both the multiplier and
//                    the arbiter that watches it
package mult_share_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'd0,
      ARB_START = 3'd1,
      ARB_WAIT  = 3'd2,
      ARB_RESP  = 3'd3,
      ARB_CLEAR = 3'd4
   } arb_state_t;

   typedef enum logic [2:0] {
      MULT_IDLE  = 3'd0,
      MULT_BIT_0 = 3'd1,
      MULT_BIT_1 = 3'd2,
      MULT_BIT_2 = 3'd3,
      MULT_BIT_3 = 3'd4,
      MULT_END   = 3'd5
   } mult_state_t;

endpackage

// File: rtl/multiplicador_4bits.sv
// Shift-add 4x4 unsigned multiplier, one operand bit per cycle.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-low reset (also used as a job clear)
//   en_i         start pulse; operands are latched on it
//   A_i, B_i     4-bit operands
//   Y_o          8-bit product, valid once fsm_state_o == MULT_END
//   fsm_state_o  current state; MULT_END is sticky until reset
module multiplicador_4bits
   import mult_share_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [OP_W-1:0]   A_i,
   input  logic [OP_W-1:0]   B_i,
   output logic [PROD_W-1:0] Y_o,
   output logic [2:0]        fsm_state_o
);

   mult_state_t         r_state;
   logic [OP_W-1:0]     r_a;
   logic [OP_W-1:0]     r_b;
   logic [PROD_W-1:0]   r_acc;
   logic [PROD_W-1:0]   w_a_ext;

   assign w_a_ext = PROD_W'(r_a);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= MULT_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
      end else begin
         case (r_state)
            MULT_IDLE: begin
               if (en_i) begin
                  r_a     <= A_i;
                  r_b     <= B_i;
                  r_acc   <= '0;
                  r_state <= MULT_BIT_0;
               end
            end
            MULT_BIT_0: begin
               if (r_b[0]) r_acc <= r_acc + w_a_ext;
               r_state <= MULT_BIT_1;
            end
            MULT_BIT_1: begin
               if (r_b[1]) r_acc <= r_acc + (w_a_ext << 1);
               r_state <= MULT_BIT_2;
            end
            MULT_BIT_2: begin
               if (r_b[2]) r_acc <= r_acc + (w_a_ext << 2);
               r_state <= MULT_BIT_3;
            end
            MULT_BIT_3: begin
               if (r_b[3]) r_acc <= r_acc + (w_a_ext << 3);
               r_state <= MULT_END;
            end
            MULT_END: r_state <= MULT_END;
            default:  r_state <= MULT_IDLE;
         endcase
      end
   end

   assign Y_o         = r_acc;
   assign fsm_state_o = r_state;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one multiplicador_4bits between N_REQ
// requesters over valid/ready request and response channels.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-low reset
//   req_valid_i    per-requester request
//   req_a_i/b_i    packed 4-bit operands, requester k at [4k+3:4k]
//   req_ready_o    one-hot accept (combinational, only in ARB_IDLE)
//   rsp_valid_o    one-hot response valid for the served requester
//   rsp_ready_i    per-requester response accept
//   rsp_y_o        product being returned
//   grant_idx_o    index of the requester currently owned
//   busy_o         high outside ARB_IDLE
//
// state     | meaning
// ARB_IDLE  | pick next requester round-robin, accept its operands
// ARB_START | one-cycle en_i pulse into the multiplier
// ARB_WAIT  | wait for MULT_END, capture product
// ARB_RESP  | hold response until the granted requester takes it
// ARB_CLEAR | one-cycle local reset of the multiplier
module mult_share_arbiter
   import mult_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_REQ-1:0]      req_valid_i,
   input  logic [OP_W*N_REQ-1:0] req_a_i,
   input  logic [OP_W*N_REQ-1:0] req_b_i,
   output logic [N_REQ-1:0]      req_ready_o,
   output logic [N_REQ-1:0]      rsp_valid_o,
   input  logic [N_REQ-1:0]      rsp_ready_i,
   output logic [PROD_W-1:0]     rsp_y_o,
   output logic [IDX_W-1:0]      grant_idx_o,
   output logic                  busy_o
);

   arb_state_t          r_state;
   logic [IDX_W-1:0]    r_last_idx;
   logic [IDX_W-1:0]    r_grant_idx;
   logic [OP_W-1:0]     r_a;
   logic [OP_W-1:0]     r_b;
   logic                r_mult_en;
   logic                r_clr_n;
   logic                r_rsp_valid;
   logic                r_busy;
   logic [PROD_W-1:0]   r_rsp_y;

   logic [OP_W-1:0]     w_a_arr [N_REQ];
   logic [OP_W-1:0]     w_b_arr [N_REQ];
   logic                w_pick_valid;
   logic [IDX_W-1:0]    w_pick_idx;
   logic                w_accept;
   logic                w_mult_rst_n;
   logic [PROD_W-1:0]   w_mult_y;
   logic [2:0]          w_mult_state;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_a_arr[g] = req_a_i[g*OP_W +: OP_W];
      assign w_b_arr[g] = req_b_i[g*OP_W +: OP_W];
   end

   // Search starts just after the last served requester so every
   // requester is reached within N_REQ jobs.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      w_pick_valid = 1'b0;
      w_pick_idx   = '0;
      cand         = 0;
      cand_idx     = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = int'(r_last_idx) + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         cand_idx = IDX_W'(cand);
         if (!w_pick_valid && req_valid_i[cand_idx]) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = cand_idx;
         end
      end
   end

   assign w_accept    = (r_state == ARB_IDLE) && w_pick_valid;
   assign req_ready_o = w_accept ? (N_REQ'(1) << w_pick_idx) : '0;
   assign rsp_valid_o = r_rsp_valid ? (N_REQ'(1) << r_grant_idx) : '0;
   assign rsp_y_o     = r_rsp_y;
   assign grant_idx_o = r_grant_idx;
   assign busy_o      = r_busy;

   // The multiplier's END state is sticky; the local clear returns it to
   // idle with a zeroed accumulator before the next job.
   assign w_mult_rst_n = rst_i & r_clr_n;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= ARB_IDLE;
         r_last_idx  <= IDX_W'(N_REQ - 1);
         r_grant_idx <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_mult_en   <= 1'b0;
         r_clr_n     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_rsp_y     <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_accept) begin
                  r_a         <= w_a_arr[w_pick_idx];
                  r_b         <= w_b_arr[w_pick_idx];
                  r_grant_idx <= w_pick_idx;
                  r_mult_en   <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= ARB_START;
               end
            end
            ARB_START: begin
               r_mult_en <= 1'b0;
               r_state   <= ARB_WAIT;
            end
            ARB_WAIT: begin
               if (w_mult_state == MULT_END) begin
                  r_rsp_y     <= w_mult_y;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if (rsp_ready_i[r_grant_idx]) begin
                  r_rsp_valid <= 1'b0;
                  r_last_idx  <= r_grant_idx;
                  r_clr_n     <= 1'b0;
                  r_state     <= ARB_CLEAR;
               end
            end
            ARB_CLEAR: begin
               r_clr_n <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ARB_IDLE;
            end
            default: begin
               r_mult_en   <= 1'b0;
               r_clr_n     <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= ARB_IDLE;
            end
         endcase
      end
   end

   multiplicador_4bits u_mult (
      .clk_i       (clk_i),
      .rst_i       (w_mult_rst_n),
      .en_i        (r_mult_en),
      .A_i         (r_a),
      .B_i         (r_b),
      .Y_o         (w_mult_y),
      .fsm_state_o (w_mult_state)
   );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with hand-computed products and
// cycle positions counted from the request handshake cycle N.
module tb_mult_share_arbiter;
   import mult_share_pkg::*;

   localparam int N = 4;

   logic          clk_sys = 1'b0;
   logic          rst_b;
   logic [N-1:0]  req_valid;
   logic [4*N-1:0] req_a;
   logic [4*N-1:0] req_b;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  rsp_valid;
   logic [N-1:0]  rsp_ready;
   logic [7:0]    rsp_y;
   logic [1:0]    grant_idx;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_sys = ~clk_sys;

   mult_share_arbiter #(.N_REQ(N)) u_dut (
      .clk_i       (clk_sys),
      .rst_i       (rst_b),
      .req_valid_i (req_valid),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .req_ready_o (req_ready),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_y_o     (rsp_y),
      .grant_idx_o (grant_idx),
      .busy_o      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      tick();
      tick();
      rst_b = 1'b1;
      tick();
   endtask

   task automatic set_ops(input int idx, input logic [3:0] a, input logic [3:0] b);
      req_a[idx*4 +: 4] = a;
      req_b[idx*4 +: 4] = b;
   endtask

   task automatic wait_rsp(inout int lat);
      while (rsp_valid == '0 && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   function automatic logic [3:0] onehot(input int idx);
      logic [3:0] v;
      v = 4'b0001;
      return v << idx;
   endfunction

   // Single job with rsp_ready already high: response in N+7, idle in N+9.
   task automatic run_job(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_y, input string tag);
      int lat;
      set_ops(idx, a, b);
      req_valid[idx] = 1'b1;
      #1;
      chk({tag, "_ready"}, req_ready, onehot(idx));
      tick();
      lat = 1;
      req_valid[idx] = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      wait_rsp(lat);
      chk({tag, "_lat"}, lat, 7);
      chk({tag, "_vld"}, rsp_valid, onehot(idx));
      chk({tag, "_y"}, rsp_y, exp_y);
      chk({tag, "_gnt"}, grant_idx, idx);
      tick();
      chk({tag, "_clr_vld"}, rsp_valid, 0);
      tick();
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int         lat;
      int         n_rsp;
      int         t_rsp [5];
      logic [7:0] rr_y [4];
      int         rr_order [5];

      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '1;
      rst_b     = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_y", rsp_y, 0);
      chk("rst_gnt", grant_idx, 0);
      chk("rst_ready", req_ready, 0);
      tick();
      rst_b = 1'b1;
      tick();

      // Single job 3*5
      run_job(0, 4'd3, 4'd5, 8'd15, "single");

      // Width extremes back to back
      run_job(0, 4'd15, 4'd15, 8'd225, "ext15x15");
      run_job(0, 4'd0,  4'd9,  8'd0,   "ext0x9");
      run_job(0, 4'd9,  4'd0,  8'd0,   "ext9x0");
      run_job(0, 4'd1,  4'd15, 8'd15,  "ext1x15");

      // Round robin from reset, all four requesters valid continuously
      do_reset();
      set_ops(0, 4'd2, 4'd3);  rr_y[0] = 8'd6;
      set_ops(1, 4'd4, 4'd5);  rr_y[1] = 8'd20;
      set_ops(2, 4'd7, 4'd8);  rr_y[2] = 8'd56;
      set_ops(3, 4'd15, 4'd2); rr_y[3] = 8'd30;
      rr_order = '{0, 1, 2, 3, 0};
      req_valid = 4'hF;
      n_rsp = 0;
      for (int c = 0; c < 70 && n_rsp < 5; c++) begin
         tick();
         if (rsp_valid != '0) begin
            chk($sformatf("rr_gnt%0d", n_rsp), grant_idx, rr_order[n_rsp]);
            chk($sformatf("rr_vld%0d", n_rsp), rsp_valid, onehot(rr_order[n_rsp]));
            chk($sformatf("rr_y%0d", n_rsp), rsp_y, rr_y[rr_order[n_rsp]]);
            t_rsp[n_rsp] = c;
            n_rsp++;
         end
      end
      chk("rr_count", n_rsp, 5);
      if (n_rsp == 5) begin
         for (int k = 1; k < 5; k++)
            chk($sformatf("rr_gap%0d", k), t_rsp[k] - t_rsp[k-1], 9);
      end
      req_valid = '0;

      // Backpressure on requester 2 with a stray ready on requester 1
      do_reset();
      rsp_ready = 4'b0010;
      set_ops(2, 4'd6, 4'd7);
      req_valid = 4'b0100;
      #1;
      chk("bp_accept", req_ready, 4'b0100);
      tick();
      lat = 1;
      req_valid = 4'b0001;
      set_ops(0, 4'd5, 4'd5);
      wait_rsp(lat);
      chk("bp_lat", lat, 7);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_vld%0d", c), rsp_valid, 4'b0100);
         chk($sformatf("bp_y%0d", c), rsp_y, 42);
         chk($sformatf("bp_noacc%0d", c), req_ready, 0);
         chk($sformatf("bp_gnt%0d", c), grant_idx, 2);
         tick();
      end
      chk("bp_still_vld", rsp_valid, 4'b0100);
      rsp_ready = 4'b0100;
      tick();
      chk("bp_clear", rsp_valid, 0);
      rsp_ready = '1;
      tick();
      chk("bp_next_pick", req_ready, 4'b0001);
      req_valid = '0;

      // Reset in N+4 of a job
      do_reset();
      set_ops(1, 4'd3, 4'd3);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      tick();
      tick();
      tick();
      chk("rmid_busy_before", busy, 1);
      rst_b = 1'b0;
      #1;
      chk("rmid_busy", busy, 0);
      chk("rmid_vld", rsp_valid, 0);
      chk("rmid_y", rsp_y, 0);
      chk("rmid_gnt", grant_idx, 0);
      chk("rmid_mult", u_dut.u_mult.fsm_state_o, MULT_IDLE);
      tick();
      rst_b = 1'b1;
      tick();
      run_job(1, 4'd4, 4'd4, 8'd16, "rmid_next");

      // Withdrawn request: 1 drops before acceptance, 3 must be granted
      do_reset();
      set_ops(0, 4'd1, 4'd1);
      req_valid = 4'b0001;
      tick();
      lat = 1;
      set_ops(1, 4'd2, 4'd2);
      set_ops(3, 4'd3, 4'd4);
      req_valid = 4'b1010;
      tick();
      tick();
      tick();
      lat = 4;
      req_valid = 4'b1000;
      wait_rsp(lat);
      chk("wd_first_gnt", grant_idx, 0);
      chk("wd_first_y", rsp_y, 1);
      tick();
      lat = 0;
      wait_rsp(lat);
      req_valid = '0;
      chk("wd_gnt", grant_idx, 3);
      chk("wd_vld", rsp_valid, 4'b1000);
      chk("wd_y", rsp_y, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
